// File: rtl/id_ex_stage_pkg.sv
// Shared constants for the ID/EX slice: default widths, ALU control width,
// register-zero constant and the forwarding-source encoding.
package id_ex_stage_pkg;

  localparam int DW_DEF    = 32;
  localparam int RW_DEF    = 5;
  localparam int CNT_W_DEF = 16;
  localparam int ALUC_W    = 4;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [2:0] {
    FWD_ZERO = 3'd0,
    FWD_EX   = 3'd1,
    FWD_MEM  = 3'd2,
    FWD_WB   = 3'd3,
    FWD_RF   = 3'd4
  } fwd_src_e;

endpackage

// File: rtl/id_ex_stage_fwd_sel.sv
// Four-source priority forwarding mux (EX > MEM > WB > register file);
// register zero never matches and always yields zero.
module fwd_sel
  import id_ex_stage_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF
) (
  input  logic [RW-1:0] r,
  input  logic [RW-1:0] ex_wn,
  input  logic          ex_wreg,
  input  logic          ex_m2reg,
  input  logic [DW-1:0] ex_alu,
  input  logic [RW-1:0] mem_wn,
  input  logic          mem_wreg,
  input  logic [DW-1:0] mem_wdata,
  input  logic [RW-1:0] wb_wn,
  input  logic          wb_wreg,
  input  logic [DW-1:0] wb_d,
  input  logic [DW-1:0] rf_q,
  output logic [DW-1:0] q
);

  fwd_src_e src;

  // Pick the youngest producer; a load in EX has no data yet and is skipped.
  always_comb begin
    src = FWD_RF;
    if (r == {RW{1'b0}}) begin
      src = FWD_ZERO;
    end else if (ex_wreg && !ex_m2reg && (ex_wn == r)) begin
      src = FWD_EX;
    end else if (mem_wreg && (mem_wn == r)) begin
      src = FWD_MEM;
    end else if (wb_wreg && (wb_wn == r)) begin
      src = FWD_WB;
    end else begin
      src = FWD_RF;
    end
  end

  // Data mux driven by the selected source.
  always_comb begin
    q = {DW{1'b0}};
    case (src)
      FWD_ZERO: q = {DW{1'b0}};
      FWD_EX:   q = ex_alu;
      FWD_MEM:  q = mem_wdata;
      FWD_WB:   q = wb_d;
      FWD_RF:   q = rf_q;
      default:  q = {DW{1'b0}};
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: operand forwarding, load-use hazard detection,
// ID/EX register with bubble insertion and a saturating stall counter.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int RW    = RW_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              id_valid,
  input  logic [RW-1:0]     id_rs,
  input  logic [RW-1:0]     id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [RW-1:0]     id_wn,
  input  logic              id_wreg,
  input  logic              id_m2reg,
  input  logic              id_wmem,
  input  logic [ALUC_W-1:0] id_aluc,
  input  logic              id_aluimm,
  input  logic [DW-1:0]     id_imm,
  input  logic [DW-1:0]     rf_qa,
  input  logic [DW-1:0]     rf_qb,
  input  logic [RW-1:0]     ex_wn,
  input  logic              ex_wreg,
  input  logic              ex_m2reg,
  input  logic [DW-1:0]     ex_alu,
  input  logic [RW-1:0]     mem_wn,
  input  logic              mem_wreg,
  input  logic [DW-1:0]     mem_wdata,
  input  logic [RW-1:0]     wb_wn,
  input  logic              wb_wreg,
  input  logic [DW-1:0]     wb_d,
  input  logic              flush,
  output logic              stall,
  output logic              e_valid,
  output logic              e_wreg,
  output logic              e_m2reg,
  output logic              e_wmem,
  output logic              e_aluimm,
  output logic [RW-1:0]     e_wn,
  output logic [ALUC_W-1:0] e_aluc,
  output logic [DW-1:0]     e_a,
  output logic [DW-1:0]     e_b,
  output logic [DW-1:0]     e_imm,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [DW-1:0] fwd_a;
  logic [DW-1:0] fwd_b;
  logic          hazard;
  logic          bubble;

  fwd_sel #(.DW(DW), .RW(RW)) u_fwd_a (
    .r(id_rs), .ex_wn(ex_wn), .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_alu(ex_alu),
    .mem_wn(mem_wn), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .wb_wn(wb_wn), .wb_wreg(wb_wreg), .wb_d(wb_d), .rf_q(rf_qa), .q(fwd_a)
  );

  fwd_sel #(.DW(DW), .RW(RW)) u_fwd_b (
    .r(id_rt), .ex_wn(ex_wn), .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_alu(ex_alu),
    .mem_wn(mem_wn), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .wb_wn(wb_wn), .wb_wreg(wb_wreg), .wb_d(wb_d), .rf_q(rf_qb), .q(fwd_b)
  );

  // Load-use hazard; flush wins and stall is held low during reset.
  always_comb begin
    hazard = id_valid && ex_wreg && ex_m2reg && (ex_wn != {RW{1'b0}}) &&
             ((id_use_rs && (ex_wn == id_rs)) || (id_use_rt && (ex_wn == id_rt)));
    stall  = hazard && !flush && clrn;
    bubble = flush || stall || !id_valid;
  end

  // ID/EX pipeline register; bubbles clear only the control bits.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      e_valid  <= 1'b0;
      e_wreg   <= 1'b0;
      e_m2reg  <= 1'b0;
      e_wmem   <= 1'b0;
      e_aluimm <= 1'b0;
      e_wn     <= {RW{1'b0}};
      e_aluc   <= {ALUC_W{1'b0}};
      e_a      <= {DW{1'b0}};
      e_b      <= {DW{1'b0}};
      e_imm    <= {DW{1'b0}};
    end else if (bubble) begin
      e_valid  <= 1'b0;
      e_wreg   <= 1'b0;
      e_m2reg  <= 1'b0;
      e_wmem   <= 1'b0;
    end else begin
      e_valid  <= 1'b1;
      e_wreg   <= id_wreg;
      e_m2reg  <= id_m2reg;
      e_wmem   <= id_wmem;
      e_aluimm <= id_aluimm;
      e_wn     <= id_wn;
      e_aluc   <= id_aluc;
      e_a      <= fwd_a;
      e_b      <= fwd_b;
      e_imm    <= id_imm;
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      stall_cnt <= {CNT_W{1'b0}};
    end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt <= stall_cnt;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed scoreboard bench for id_ex_stage: a 16-bit-counter instance and a
// 2-bit-counter instance share all inputs.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        clrn;
  logic        id_valid, id_use_rs, id_use_rt, id_wreg, id_m2reg, id_wmem, id_aluimm;
  logic [4:0]  id_rs, id_rt, id_wn, ex_wn, mem_wn, wb_wn;
  logic [3:0]  id_aluc;
  logic [31:0] id_imm, rf_qa, rf_qb, ex_alu, mem_wdata, wb_d;
  logic        ex_wreg, ex_m2reg, mem_wreg, wb_wreg, flush;

  logic        stall, e_valid, e_wreg, e_m2reg, e_wmem, e_aluimm;
  logic [4:0]  e_wn;
  logic [3:0]  e_aluc;
  logic [31:0] e_a, e_b, e_imm;
  logic [15:0] stall_cnt;

  logic        s_stall, s_valid, s_wreg, s_m2reg, s_wmem, s_aluimm;
  logic [4:0]  s_wn;
  logic [3:0]  s_aluc;
  logic [31:0] s_a, s_b, s_imm;
  logic [1:0]  s_cnt;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;

  typedef struct { int sel; logic [31:0] exp; } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .clrn(clrn), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wn(id_wn), .id_wreg(id_wreg),
    .id_m2reg(id_m2reg), .id_wmem(id_wmem), .id_aluc(id_aluc), .id_aluimm(id_aluimm),
    .id_imm(id_imm), .rf_qa(rf_qa), .rf_qb(rf_qb), .ex_wn(ex_wn), .ex_wreg(ex_wreg),
    .ex_m2reg(ex_m2reg), .ex_alu(ex_alu), .mem_wn(mem_wn), .mem_wreg(mem_wreg),
    .mem_wdata(mem_wdata), .wb_wn(wb_wn), .wb_wreg(wb_wreg), .wb_d(wb_d), .flush(flush),
    .stall(stall), .e_valid(e_valid), .e_wreg(e_wreg), .e_m2reg(e_m2reg), .e_wmem(e_wmem),
    .e_aluimm(e_aluimm), .e_wn(e_wn), .e_aluc(e_aluc), .e_a(e_a), .e_b(e_b),
    .e_imm(e_imm), .stall_cnt(stall_cnt)
  );

  id_ex_stage #(.CNT_W(2)) dut_small (
    .clk(clk), .clrn(clrn), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wn(id_wn), .id_wreg(id_wreg),
    .id_m2reg(id_m2reg), .id_wmem(id_wmem), .id_aluc(id_aluc), .id_aluimm(id_aluimm),
    .id_imm(id_imm), .rf_qa(rf_qa), .rf_qb(rf_qb), .ex_wn(ex_wn), .ex_wreg(ex_wreg),
    .ex_m2reg(ex_m2reg), .ex_alu(ex_alu), .mem_wn(mem_wn), .mem_wreg(mem_wreg),
    .mem_wdata(mem_wdata), .wb_wn(wb_wn), .wb_wreg(wb_wreg), .wb_d(wb_d), .flush(flush),
    .stall(s_stall), .e_valid(s_valid), .e_wreg(s_wreg), .e_m2reg(s_m2reg), .e_wmem(s_wmem),
    .e_aluimm(s_aluimm), .e_wn(s_wn), .e_aluc(s_aluc), .e_a(s_a), .e_b(s_b),
    .e_imm(s_imm), .stall_cnt(s_cnt)
  );

  function automatic string sel_name(input int sel);
    case (sel)
      0: return "e_valid";  1: return "e_wreg";   2: return "e_m2reg";
      3: return "e_wmem";   4: return "e_aluimm"; 5: return "e_wn";
      6: return "e_aluc";   7: return "e_a";      8: return "e_b";
      9: return "e_imm";    10: return "stall_cnt"; 11: return "small_cnt";
      default: return "unknown";
    endcase
  endfunction

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      0: return {31'd0, e_valid};  1: return {31'd0, e_wreg};
      2: return {31'd0, e_m2reg};  3: return {31'd0, e_wmem};
      4: return {31'd0, e_aluimm}; 5: return {27'd0, e_wn};
      6: return {28'd0, e_aluc};   7: return e_a;
      8: return e_b;               9: return e_imm;
      10: return {16'd0, stall_cnt};
      11: return {30'd0, s_cnt};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int sel, input logic [31:0] exp);
    exp_t e;
    e.sel = sel;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic push_cnt();
    push(10, exp_cnt);
    push(11, (exp_cnt > 3) ? 32'd3 : exp_cnt);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(sel_name(e.sel), observe(e.sel), e.exp);
    end
  endtask

  task automatic idle();
    id_valid = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    id_wn = 5'd0; id_wreg = 1'b0; id_m2reg = 1'b0; id_wmem = 1'b0; id_aluc = 4'd0;
    id_aluimm = 1'b0; id_imm = 32'd0; rf_qa = 32'd0; rf_qb = 32'd0;
    ex_wn = 5'd0; ex_wreg = 1'b0; ex_m2reg = 1'b0; ex_alu = 32'd0;
    mem_wn = 5'd0; mem_wreg = 1'b0; mem_wdata = 32'd0;
    wb_wn = 5'd0; wb_wreg = 1'b0; wb_d = 32'd0; flush = 1'b0;
  endtask

  task automatic load_use_rs7();
    idle();
    id_valid = 1'b1; id_rs = 5'd7; id_use_rs = 1'b1; id_wreg = 1'b1; id_wn = 5'd8;
    ex_wn = 5'd7; ex_wreg = 1'b1; ex_m2reg = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    clrn = 1'b0;
    load_use_rs7();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_e_valid", {31'd0, e_valid}, 32'd0);
    chk("rst_e_a", e_a, 32'd0);
    chk("rst_cnt", {16'd0, stall_cnt}, 32'd0);
    idle();
    #2 clrn = 1'b1;
    @(posedge clk); #1;

    // EX beats MEM; full field capture
    idle();
    id_valid = 1'b1; id_rs = 5'd3; id_use_rs = 1'b1; id_rt = 5'd4; id_use_rt = 1'b1;
    id_wn = 5'd9; id_wreg = 1'b1; id_wmem = 1'b1; id_aluc = 4'hA; id_aluimm = 1'b1;
    id_imm = 32'h1234; rf_qa = 32'h99; rf_qb = 32'h44;
    ex_wn = 5'd3; ex_wreg = 1'b1; ex_alu = 32'h11;
    mem_wn = 5'd3; mem_wreg = 1'b1; mem_wdata = 32'h22;
    wb_wn = 5'd3; wb_wreg = 1'b1; wb_d = 32'h33;
    #1 chk("ex_fwd_stall", {31'd0, stall}, 32'd0);
    push(0, 32'd1); push(1, 32'd1); push(2, 32'd0); push(3, 32'd1); push(4, 32'd1);
    push(5, 32'd9); push(6, 32'hA); push(7, 32'h11); push(8, 32'h44); push(9, 32'h1234);
    tick();
    ex_wreg = 1'b0;  push(7, 32'h22); tick();
    mem_wreg = 1'b0; push(7, 32'h33); tick();
    wb_wreg = 1'b0;  push(7, 32'h99); tick();
    ex_wreg = 1'b1; ex_m2reg = 1'b1; mem_wreg = 1'b1; id_use_rs = 1'b0;
    push(7, 32'h22); tick();

    // WB forwarding on rt, then register file
    idle();
    id_valid = 1'b1; id_rt = 5'd5; id_use_rt = 1'b1; rf_qb = 32'd0;
    wb_wn = 5'd5; wb_wreg = 1'b1; wb_d = 32'hCAFE;
    push(8, 32'hCAFE); tick();
    wb_wreg = 1'b0; rf_qb = 32'h1357;
    push(8, 32'h1357); tick();

    // r0 never forwards, never stalls
    idle();
    id_valid = 1'b1; id_rs = 5'd0; id_use_rs = 1'b1; ex_wn = 5'd0; ex_wreg = 1'b1;
    ex_alu = 32'hFF; rf_qa = 32'd0;
    push(7, 32'd0); tick();
    ex_m2reg = 1'b1;
    #1 chk("r0_load_stall", {31'd0, stall}, 32'd0);
    push(0, 32'd1); push(7, 32'd0); tick();

    // load-use on rs: one stall, then forward from MEM
    load_use_rs7();
    #1 chk("lu_rs_stall", {31'd0, stall}, 32'd1);
    exp_cnt++;
    push(0, 32'd0); push(1, 32'd0); push_cnt(); tick();
    ex_wreg = 1'b0; ex_m2reg = 1'b0; mem_wn = 5'd7; mem_wreg = 1'b1; mem_wdata = 32'h77;
    #1 chk("lu_after_stall", {31'd0, stall}, 32'd0);
    push(0, 32'd1); push(7, 32'h77); push_cnt(); tick();

    // load-use on rt, non-use, invalid
    load_use_rs7();
    id_use_rs = 1'b0; id_rs = 5'd2; id_rt = 5'd7; id_use_rt = 1'b1;
    #1 chk("lu_rt_stall", {31'd0, stall}, 32'd1);
    exp_cnt++;
    push(0, 32'd0); push_cnt(); tick();
    id_use_rt = 1'b0;
    #1 chk("no_use_stall", {31'd0, stall}, 32'd0);
    push(0, 32'd1); tick();
    load_use_rs7(); id_valid = 1'b0;
    #1 chk("invalid_stall", {31'd0, stall}, 32'd0);
    push(0, 32'd0); push_cnt(); tick();

    // hazard with flush: bubble, no stall, not counted
    load_use_rs7(); flush = 1'b1;
    #1 chk("flush_stall", {31'd0, stall}, 32'd0);
    push(0, 32'd0); push(1, 32'd0); push_cnt(); tick();

    // three more stalls: small counter saturates at 3
    load_use_rs7();
    for (int i = 0; i < 3; i++) begin
      exp_cnt++;
      push_cnt(); tick();
    end

    // reset asserted mid-stall
    load_use_rs7();
    #1 chk("pre_rst_stall", {31'd0, stall}, 32'd1);
    #2 clrn = 1'b0;
    #1;
    chk("arst_stall", {31'd0, stall}, 32'd0);
    chk("arst_e_valid", {31'd0, e_valid}, 32'd0);
    chk("arst_e_wreg", {31'd0, e_wreg}, 32'd0);
    chk("arst_e_wn", {27'd0, e_wn}, 32'd0);
    chk("arst_e_a", e_a, 32'd0);
    chk("arst_e_b", e_b, 32'd0);
    chk("arst_e_imm", e_imm, 32'd0);
    chk("arst_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("arst_small_cnt", {30'd0, s_cnt}, 32'd0);
    #2 clrn = 1'b1;
    #1 chk("post_rst_stall", {31'd0, stall}, 32'd1);
    exp_cnt = 1;
    push(0, 32'd0); push_cnt(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
